rca_lsq_arbiter: RTL and testbench
==================================

# rca_lsq_arbiter

Shares the single LSQ request/response port among `NUM_UNITS` reconfigurable-region operation units (OUs). It performs round-robin arbitration of OU memory requests onto the LSQ. It tracks outstanding loads in issue order and routes each `load_complete`/`load_data` return to the OU that issued the load. It sits between the PR-module LSQ interfaces and the Taiga LSQ input.

## Interface
Parameters:
- `NUM_UNITS`, default 4: number of OU request ports (≥2).
- `MAX_LOADS`, default 4: outstanding-load tracking depth (power of two, ≥2).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `unit_addr`  in  NUM_UNITS*XLEN  per-OU address; unit i occupies bits [i*XLEN +: XLEN].
- `unit_data`  in  NUM_UNITS*XLEN  per-OU store data.
- `unit_fn3`  in  NUM_UNITS*3  per-OU fn3.
- `unit_load`, `unit_store`, `unit_new_request`  in  NUM_UNITS  per-OU request qualifiers.
- `unit_lsq_full`  out  NUM_UNITS  per-OU backpressure; low only in the cycle that OU's request is accepted.
- `unit_load_data`  out  XLEN  `load_data` broadcast to all OUs.
- `unit_load_complete`  out  NUM_UNITS  one-hot load return to the owning OU.
- `addr`, `data`  out  XLEN  forwarded fields of the granted request.
- `fn3`  out  3  forwarded fn3 of the granted request.
- `load`, `store`, `new_request`  out  1  LSQ request.
- `lsq_full`  in  1  LSQ backpressure.
- `load_data`  in  XLEN  LSQ load result.
- `load_complete`  in  1  LSQ load-return strobe; returns arrive in issue order.
- `outstanding_loads`  out  $clog2(MAX_LOADS)+1  current tracked-load count.
- `load_underflow`  out  1  sticky error flag.

## Operation
- Eligibility: unit i is eligible when `unit_new_request[i]` is high and (`unit_load[i]` or `unit_store[i]`) is high. A request with `unit_load[i]` high is a load, including when `unit_store[i]` is also high; it is then forwarded with `load`=1 and `store`=0.
- Load masking: when the tracker is full (count == MAX_LOADS at the start of the cycle), loads are ineligible. Stores remain eligible.
- Grant: combinational round-robin. The first eligible unit scanning upward from `rr_ptr`, wrapping at NUM_UNITS, wins.
- LSQ request: `addr`/`data`/`fn3`/`load`/`store` carry the winner's fields. When there is no winner they are 0. `new_request` = winner exists AND `lsq_full` low.
- Acceptance: a request is accepted when `new_request` is high. `unit_lsq_full[winner]` is low in that cycle; all other bits of `unit_lsq_full` are high. OUs hold their request fields until accepted.
- `rr_ptr`: on acceptance it becomes (winner+1) mod NUM_UNITS. Otherwise it is unchanged.
- Tracker: a circular FIFO of unit indices, MAX_LOADS entries deep, with read pointer, write pointer and count.
  - Push: an accepted load pushes the winner index.
  - Pop: `load_complete` pops the head and asserts `unit_load_complete[head]` in the same cycle.
  - Pointers wrap modulo MAX_LOADS.
- Simultaneous push and pop: both take effect and the count is unchanged. This cannot happen when full, because loads are masked.
- Underflow: `load_complete` while the tracker is empty is dropped. `unit_load_complete` stays all 0 and `load_underflow` is set. `load_underflow` clears only on reset.

## Timing
- The request path is zero-latency (combinational from `unit_*`/`lsq_full` to LSQ outputs and `unit_lsq_full`). The return path is also zero-latency (`load_complete` to `unit_load_complete`).
- Registered state is limited to `rr_ptr`, the tracker FIFO (entries, pointers, count) and `load_underflow`. All of it updates on the `clk` rising edge.
- The `outstanding_loads` output and the load mask reflect the registered count, so a pop frees a slot for arbitration one cycle later.
- Reset values: `rr_ptr`=0, tracker empty, `outstanding_loads`=0, `load_underflow`=0.
- While `rst` is asserted with no requests present, all LSQ outputs are 0, `unit_lsq_full` is all 1 and `unit_load_complete` is all 0.
- Reset asserted mid-operation discards all tracked loads. Returns arriving after reset with an empty tracker are handled as underflow.

## Test plan
- Round-robin fairness: NUM_UNITS=4, all four units request stores continuously, `lsq_full`=0. Required: accepts in order 0,1,2,3,0, one per cycle, with the matching `unit_lsq_full` bit low each cycle.
- Backpressure: unit 2 requests a load while `lsq_full`=1 for 3 cycles. Required: `new_request`=0, `unit_lsq_full[2]`=1 and `rr_ptr` unchanged for those 3 cycles; accepted in cycle 4 and `outstanding_loads` becomes 1.
- Return routing: units 1, 3, 1 issue loads, then three `load_complete` pulses with `load_data` 0xA, 0xB, 0xC. Required: `unit_load_complete` = 0010, 1000, 0010, with `unit_load_data` matching each pulse.
- Full mask: MAX_LOADS=4 and 4 loads outstanding; unit 0 requests a load and unit 1 a store. Required: unit 1's store is accepted and unit 0 is stalled. Unit 0's load is accepted the cycle after the next `load_complete`.
- Simultaneous push/pop: 2 loads outstanding; an accepted load and `load_complete` occur in the same cycle. Required: count stays 2, the head is routed correctly, and the FIFO wraps correctly over 10 iterations.
- Underflow and reset: `load_complete` with the tracker empty. Required: no `unit_load_complete` and `load_underflow`=1. Asynchronous `rst` mid-stream then clears the flag, count and `rr_ptr` immediately.

Source files
------------

// File: rtl/rca_lsq_arbiter_if.sv
// LSQ sharing bundle between reconfigurable operation units and the LSQ.
// master drives OU requests and LSQ returns; slave is the arbiter.
interface rca_lsq_arbiter_if #(
  parameter int NUM_UNITS = 4,
  parameter int MAX_LOADS = 4,
  parameter int XLEN      = 32
);
  localparam int CW = $clog2(MAX_LOADS) + 1;

  logic [NUM_UNITS*XLEN-1:0] unit_addr;
  logic [NUM_UNITS*XLEN-1:0] unit_data;
  logic [NUM_UNITS*3-1:0]    unit_fn3;
  logic [NUM_UNITS-1:0]      unit_load;
  logic [NUM_UNITS-1:0]      unit_store;
  logic [NUM_UNITS-1:0]      unit_new_request;
  logic [NUM_UNITS-1:0]      unit_lsq_full;
  logic [XLEN-1:0]           unit_load_data;
  logic [NUM_UNITS-1:0]      unit_load_complete;

  logic [XLEN-1:0]           addr;
  logic [XLEN-1:0]           data;
  logic [2:0]                fn3;
  logic                      load;
  logic                      store;
  logic                      new_request;
  logic                      lsq_full;
  logic [XLEN-1:0]           load_data;
  logic                      load_complete;

  logic [CW-1:0]             outstanding_loads;
  logic                      load_underflow;

  modport master (
    output unit_addr,
    output unit_data,
    output unit_fn3,
    output unit_load,
    output unit_store,
    output unit_new_request,
    output lsq_full,
    output load_data,
    output load_complete,
    input  unit_lsq_full,
    input  unit_load_data,
    input  unit_load_complete,
    input  addr,
    input  data,
    input  fn3,
    input  load,
    input  store,
    input  new_request,
    input  outstanding_loads,
    input  load_underflow
  );

  modport slave (
    input  unit_addr,
    input  unit_data,
    input  unit_fn3,
    input  unit_load,
    input  unit_store,
    input  unit_new_request,
    input  lsq_full,
    input  load_data,
    input  load_complete,
    output unit_lsq_full,
    output unit_load_data,
    output unit_load_complete,
    output addr,
    output data,
    output fn3,
    output load,
    output store,
    output new_request,
    output outstanding_loads,
    output load_underflow
  );
endinterface

// File: rtl/rca_lsq_arbiter.sv
// Round-robin sharing of one LSQ port among NUM_UNITS operation units,
// with an in-order tracker that routes load returns back to their issuer.
module rca_lsq_arbiter #(
  parameter int NUM_UNITS = 4,
  parameter int MAX_LOADS = 4,
  parameter int XLEN      = 32
) (
  input  logic             clk,
  input  logic             rst,
  rca_lsq_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_UNITS);
  localparam int PW = $clog2(MAX_LOADS);
  localparam int CW = PW + 1;

  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] fifo_q [MAX_LOADS];
  logic [IW-1:0] fifo_d [MAX_LOADS];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          uf_q, uf_d;

  logic                 full_w;
  logic                 empty_w;
  logic [NUM_UNITS-1:0] elig;
  logic                 found;
  logic [IW-1:0]        win;
  logic                 accept;
  logic                 push;
  logic                 pop;

  always_comb begin
    full_w  = (cnt_q == CW'(MAX_LOADS));
    empty_w = (cnt_q == '0);
    for (int i = 0; i < NUM_UNITS; i++) begin
      elig[i] = bus.unit_new_request[i]
              & (bus.unit_load[i] | bus.unit_store[i])
              & ~(bus.unit_load[i] & full_w);
    end
  end

  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_UNITS) idx = idx - NUM_UNITS;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  always_comb begin
    bus.addr  = '0;
    bus.data  = '0;
    bus.fn3   = '0;
    bus.load  = 1'b0;
    bus.store = 1'b0;
    if (found) begin
      bus.addr  = bus.unit_addr[win*XLEN +: XLEN];
      bus.data  = bus.unit_data[win*XLEN +: XLEN];
      bus.fn3   = bus.unit_fn3[win*3 +: 3];
      bus.load  = bus.unit_load[win];
      // A request flagged as both load and store goes out as a load.
      bus.store = bus.unit_store[win] & ~bus.unit_load[win];
    end
  end

  always_comb begin
    accept          = found & ~bus.lsq_full;
    push            = accept & bus.unit_load[win];
    pop             = bus.load_complete & ~empty_w;
    bus.new_request = accept;
    bus.unit_lsq_full = '1;
    if (accept) bus.unit_lsq_full[win] = 1'b0;
    bus.unit_load_complete = '0;
    if (pop) bus.unit_load_complete[fifo_q[rd_q]] = 1'b1;
    bus.unit_load_data    = bus.load_data;
    bus.outstanding_loads = cnt_q;
    bus.load_underflow    = uf_q;
  end

  always_comb begin
    rr_d   = rr_q;
    fifo_d = fifo_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    uf_d   = uf_q | (bus.load_complete & empty_w);
    if (accept) begin
      rr_d = (win == IW'(NUM_UNITS - 1)) ? '0 : win + IW'(1);
    end
    if (push) begin
      fifo_d[wr_q] = win;
      wr_d         = wr_q + PW'(1);
    end
    if (pop) rd_d = rd_q + PW'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q  <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      uf_q  <= 1'b0;
      for (int i = 0; i < MAX_LOADS; i++) fifo_q[i] <= '0;
    end else begin
      rr_q   <= rr_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      uf_q   <= uf_d;
      fifo_q <= fifo_d;
    end
  end
endmodule

// File: tb/tb_rca_lsq_arbiter.sv
// Bench for rca_lsq_arbiter: vector table for arbitration, scripted
// sequences for backpressure, returns, full mask, push/pop and reset.
module tb_rca_lsq_arbiter;
  localparam int N = 4;
  localparam int M = 4;
  localparam int X = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rca_lsq_arbiter_if #(.NUM_UNITS(N), .MAX_LOADS(M), .XLEN(X)) bus ();

  rca_lsq_arbiter #(.NUM_UNITS(N), .MAX_LOADS(M), .XLEN(X)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   tests = 0;
  int   fails = 0;
  int   q[$];
  logic exp_uf = 1'b0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] ld;
    logic [3:0] st;
    logic       full;
    int         win;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One cycle: drive at negedge, check mid-cycle, update scoreboard.
  task automatic cyc(input logic [3:0] req, input logic [3:0] ld,
                     input logic [3:0] st, input logic full,
                     input logic lc, input logic [31:0] d,
                     input int win, input string nm);
    logic       acc;
    logic [3:0] eulf;
    logic [3:0] eulc;
    bus.unit_new_request = req;
    bus.unit_load        = ld;
    bus.unit_store       = st;
    bus.lsq_full         = full;
    bus.load_complete    = lc;
    bus.load_data        = d;
    #1;
    acc  = (win >= 0) && !full;
    eulf = 4'hF;
    if (acc) eulf[win] = 1'b0;
    chk({nm, ".new_request"}, 64'(bus.new_request), 64'(acc));
    chk({nm, ".unit_lsq_full"}, 64'(bus.unit_lsq_full), 64'(eulf));
    if (win >= 0) begin
      chk({nm, ".addr"}, 64'(bus.addr), 64'(32'h100 + win));
      chk({nm, ".data"}, 64'(bus.data), 64'(32'h200 + win));
      chk({nm, ".fn3"}, 64'(bus.fn3), 64'(win));
      chk({nm, ".load"}, 64'(bus.load), 64'(ld[win]));
      chk({nm, ".store"}, 64'(bus.store), 64'(st[win] & ~ld[win]));
    end else begin
      chk({nm, ".addr0"}, 64'(bus.addr), 64'd0);
      chk({nm, ".load0"}, 64'(bus.load), 64'd0);
    end
    chk({nm, ".outstanding"}, 64'(bus.outstanding_loads), 64'(q.size()));
    chk({nm, ".underflow"}, 64'(bus.load_underflow), 64'(exp_uf));
    eulc = 4'h0;
    if (lc) begin
      if (q.size() > 0) begin
        eulc[q[0]] = 1'b1;
        chk({nm, ".unit_load_data"}, 64'(bus.unit_load_data), 64'(d));
        void'(q.pop_front());
      end else begin
        exp_uf = 1'b1;
      end
    end
    chk({nm, ".unit_load_complete"}, 64'(bus.unit_load_complete),
        64'(eulc));
    if (acc && ld[win]) q.push_back(win);
    @(negedge clk);
  endtask

  task automatic idle(input string nm);
    cyc(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 32'h0, -1, nm);
  endtask

  task automatic ret(input logic [31:0] d, input string nm);
    cyc(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, d, -1, nm);
  endtask

  task automatic ld1(input int u, input string nm);
    logic [3:0] m;
    m = 4'h0;
    m[u] = 1'b1;
    cyc(m, m, 4'h0, 1'b0, 1'b0, 32'h0, u, nm);
  endtask

  initial begin
    tbl[0] = '{4'hF, 4'h0, 4'hF, 1'b0, 0};
    tbl[1] = '{4'hF, 4'h0, 4'hF, 1'b0, 1};
    tbl[2] = '{4'hF, 4'h0, 4'hF, 1'b0, 2};
    tbl[3] = '{4'hF, 4'h0, 4'hF, 1'b0, 3};
    tbl[4] = '{4'hF, 4'h0, 4'hF, 1'b0, 0};
    tbl[5] = '{4'h0, 4'h0, 4'h0, 1'b0, -1};
    tbl[6] = '{4'h1, 4'h0, 4'h1, 1'b1, 0};
    tbl[7] = '{4'h1, 4'h0, 4'h1, 1'b0, 0};
    tbl[8] = '{4'h9, 4'h0, 4'h1, 1'b0, 0};
    tbl[9] = '{4'h4, 4'h4, 4'h4, 1'b0, 2};

    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      bus.unit_addr[i*X +: X] = 32'h100 + i;
      bus.unit_data[i*X +: X] = 32'h200 + i;
      bus.unit_fn3[i*3 +: 3]  = 3'(i);
    end
    bus.unit_new_request = '0;
    bus.unit_load        = '0;
    bus.unit_store       = '0;
    bus.lsq_full         = 1'b0;
    bus.load_complete    = 1'b0;
    bus.load_data        = '0;
    #1;
    chk("rst.new_request", 64'(bus.new_request), 64'd0);
    chk("rst.addr", 64'(bus.addr), 64'd0);
    chk("rst.store", 64'(bus.store), 64'd0);
    chk("rst.unit_lsq_full", 64'(bus.unit_lsq_full), 64'hF);
    chk("rst.unit_load_complete", 64'(bus.unit_load_complete), 64'd0);
    chk("rst.outstanding", 64'(bus.outstanding_loads), 64'd0);
    chk("rst.underflow", 64'(bus.load_underflow), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      cyc(tbl[i].req, tbl[i].ld, tbl[i].st, tbl[i].full, 1'b0, 32'h0,
          tbl[i].win, $sformatf("vec%0d", i));
    ret(32'h55, "ret0");

    // Backpressure: rr sits at 1 during the stall, so unit 2 beats unit 3.
    cyc(4'h1, 4'h0, 4'h1, 1'b0, 1'b0, 32'h0, 0, "bp_pre");
    for (int i = 0; i < 3; i++)
      cyc(4'h4, 4'h4, 4'h0, 1'b1, 1'b0, 32'h0, 2, $sformatf("bp%0d", i));
    cyc(4'hC, 4'h4, 4'h8, 1'b0, 1'b0, 32'h0, 2, "bp_acc");
    cyc(4'h8, 4'h0, 4'h8, 1'b0, 1'b0, 32'h0, 3, "bp_cnt");
    ret(32'h66, "bp_ret");

    ld1(1, "rt_ld1");
    ld1(3, "rt_ld3");
    ld1(1, "rt_ld1b");
    ret(32'hA, "rt_a");
    ret(32'hB, "rt_b");
    ret(32'hC, "rt_c");

    ld1(0, "fm_ld0");
    ld1(1, "fm_ld1");
    ld1(2, "fm_ld2");
    ld1(3, "fm_ld3");
    cyc(4'h3, 4'h1, 4'h2, 1'b0, 1'b0, 32'h0, 1, "fm_store");
    cyc(4'h1, 4'h1, 4'h0, 1'b0, 1'b0, 32'h0, -1, "fm_stall");
    cyc(4'h1, 4'h1, 4'h0, 1'b0, 1'b1, 32'h77, -1, "fm_pop");
    cyc(4'h1, 4'h1, 4'h0, 1'b0, 1'b0, 32'h0, 0, "fm_acc");
    for (int i = 0; i < 4; i++) ret(32'h300 + i, $sformatf("fm_ret%0d", i));

    ld1(0, "sim_ld0");
    ld1(1, "sim_ld1");
    for (int i = 0; i < 10; i++) begin
      logic [3:0] m;
      m = 4'h0;
      m[i % 4] = 1'b1;
      cyc(m, m, 4'h0, 1'b0, 1'b1, 32'h1000 + i, i % 4,
          $sformatf("sim%0d", i));
    end
    ret(32'h2000, "sim_ret0");
    ret(32'h2001, "sim_ret1");

    ret(32'hDEAD, "uf");
    idle("uf_hold");

    ld1(2, "rs_ld2");
    bus.unit_new_request = 4'h8;
    bus.unit_store       = 4'h8;
    bus.unit_load        = 4'h0;
    #2;
    rst = 1'b1;
    #1;
    chk("rs.outstanding", 64'(bus.outstanding_loads), 64'd0);
    chk("rs.underflow", 64'(bus.load_underflow), 64'd0);
    bus.unit_new_request = 4'h0;
    bus.unit_store       = 4'h0;
    #1;
    chk("rs.new_request", 64'(bus.new_request), 64'd0);
    chk("rs.addr", 64'(bus.addr), 64'd0);
    chk("rs.unit_lsq_full", 64'(bus.unit_lsq_full), 64'hF);
    chk("rs.unit_load_complete", 64'(bus.unit_load_complete), 64'd0);
    q.delete();
    exp_uf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cyc(4'hF, 4'h0, 4'hF, 1'b0, 1'b0, 32'h0, 0, "post_rst");
    ret(32'hBEEF, "post_rst_uf");
    idle("post_rst_hold");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
